// File: rtl/a23_cache_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// a23_cache_flush_ctrl_pkg
//   Shared cache geometry defaults and flush controller types. The cache and
//   the flush controller both take their geometry from these defaults, so the
//   two can never disagree on line count, way count or tag width.
// ---------------------------------------------------------------------------
package a23_cache_flush_ctrl_pkg;

    // Cache geometry defaults
    localparam int A23_CACHE_LINES = 256;
    localparam int A23_CACHE_WAYS  = 4;
    localparam int A23_TAG_WIDTH   = 20;

    // Completed-sweep counter width and its saturation value
    localparam int          FLUSH_COUNT_W   = 16;
    localparam logic [15:0] FLUSH_COUNT_MAX = 16'hffff;

    // Sweep FSM encoding
    typedef enum logic {
        FLUSH_IDLE  = 1'b0,
        FLUSH_SWEEP = 1'b1
    } flush_state_t;

    // Saturating increment: holds at the maximum instead of wrapping
    function automatic logic [FLUSH_COUNT_W-1:0] sat_inc(input logic [FLUSH_COUNT_W-1:0] v);
        return (v == FLUSH_COUNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/a23_cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// a23_cache_flush_ctrl
//   Turns the co-processor 15 flush strobe into a full invalidation sweep of
//   the cache tag RAM (all ways in parallel, one line index per accepted
//   write). Reset starts a mandatory sweep because tag RAM contents are
//   undefined at power-on. While sweeping, the core is stalled and the cache
//   enable seen by the cache is masked.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_cache_flush    flush strobe (already qualified by !fetch_stall)
//   i_cache_enable   cache enable bit from co-pro 15
//   i_tag_wready     tag RAM accepts the presented write this cycle
//   o_tag_wenable    per-way tag write enable, all bits equal
//   o_tag_waddr      line index being invalidated
//   o_tag_wdata      constant zero (valid bit cleared)
//   o_flush_busy     sweep in progress / fetch stall request
//   o_flush_done     one-cycle pulse after the last write is accepted
//   o_cache_enable   i_cache_enable masked by o_flush_busy
//   o_flush_count    completed sweeps, saturating
// ---------------------------------------------------------------------------
module a23_cache_flush_ctrl
    import a23_cache_flush_ctrl_pkg::*;
#(
    parameter int CACHE_LINES     = A23_CACHE_LINES,
    parameter int WAYS            = A23_CACHE_WAYS,
    parameter int LINE_ADDR_WIDTH = $clog2(CACHE_LINES),
    parameter int TAG_WIDTH       = A23_TAG_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cache_flush,
    input  logic                       i_cache_enable,
    input  logic                       i_tag_wready,
    output logic [WAYS-1:0]            o_tag_wenable,
    output logic [LINE_ADDR_WIDTH-1:0] o_tag_waddr,
    output logic [TAG_WIDTH-1:0]       o_tag_wdata,
    output logic                       o_flush_busy,
    output logic                       o_flush_done,
    output logic                       o_cache_enable,
    output logic [FLUSH_COUNT_W-1:0]   o_flush_count
);

    localparam logic [LINE_ADDR_WIDTH-1:0] LAST_LINE = LINE_ADDR_WIDTH'(CACHE_LINES - 1);

    flush_state_t               state;
    logic [LINE_ADDR_WIDTH-1:0] line_cnt;
    logic                       done_q;
    logic [FLUSH_COUNT_W-1:0]   flush_count_q;

    // Reset lands in SWEEP so the power-on invalidation needs no trigger.
    // A strobe always wins: in IDLE it starts a sweep, in SWEEP it restarts
    // from line 0 and suppresses completion even on the final write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= FLUSH_SWEEP;
            line_cnt      <= '0;
            done_q        <= 1'b0;
            flush_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                FLUSH_IDLE: begin
                    if (i_cache_flush) begin
                        state    <= FLUSH_SWEEP;
                        line_cnt <= '0;
                    end
                end
                FLUSH_SWEEP: begin
                    if (i_cache_flush) begin
                        line_cnt <= '0;
                    end else if (i_tag_wready) begin
                        if (line_cnt == LAST_LINE) begin
                            line_cnt      <= '0;
                            state         <= FLUSH_IDLE;
                            done_q        <= 1'b1;
                            flush_count_q <= sat_inc(flush_count_q);
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end
                end
                default: state <= FLUSH_SWEEP;
            endcase
        end
    end

    assign o_flush_busy   = (state == FLUSH_SWEEP);
    assign o_tag_wenable  = {WAYS{o_flush_busy}};
    assign o_tag_waddr    = line_cnt;
    assign o_tag_wdata    = '0;
    assign o_flush_done   = done_q;
    assign o_cache_enable = i_cache_enable & ~o_flush_busy;
    assign o_flush_count  = flush_count_q;

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_a23_cache_flush_ctrl
//   Directed bench for the cache flush controller at default geometry
//   (256 lines, 4 ways, 20-bit tags). Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_a23_cache_flush_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_cache_flush;
    logic        i_cache_enable;
    logic        i_tag_wready;
    logic [3:0]  o_tag_wenable;
    logic [7:0]  o_tag_waddr;
    logic [19:0] o_tag_wdata;
    logic        o_flush_busy;
    logic        o_flush_done;
    logic        o_cache_enable;
    logic [15:0] o_flush_count;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;

    a23_cache_flush_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cache_flush  (i_cache_flush),
        .i_cache_enable (i_cache_enable),
        .i_tag_wready   (i_tag_wready),
        .o_tag_wenable  (o_tag_wenable),
        .o_tag_waddr    (o_tag_waddr),
        .o_tag_wdata    (o_tag_wdata),
        .o_flush_busy   (o_flush_busy),
        .o_flush_done   (o_flush_done),
        .o_cache_enable (o_cache_enable),
        .o_flush_count  (o_flush_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, tally done pulses
    task automatic step();
        @(negedge i_clk);
        if (o_flush_done === 1'b1) done_seen++;
    endtask

    // Walk n written lines starting at index 'start' with ready high,
    // checking index progression and busy; returns the error count.
    task automatic walk(input int start, input int n, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (o_tag_waddr !== 8'(start + i) || o_flush_busy !== 1'b1 ||
                o_tag_wenable !== 4'hf || o_flush_done !== 1'b0) errs++;
            step();
        end
    endtask

    task automatic strobe();
        i_cache_flush = 1'b1;
        step();
        i_cache_flush = 1'b0;
    endtask

    initial begin
        int errs;
        int exp_idx;
        int cyc;
        int d0;

        i_rst          = 1'b1;
        i_cache_flush  = 1'b0;
        i_cache_enable = 1'b1;
        i_tag_wready   = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst_busy",    32'(o_flush_busy),   32'h1);
        chk("rst_wenable", 32'(o_tag_wenable),  32'hf);
        chk("rst_waddr",   32'(o_tag_waddr),    32'h0);
        chk("rst_wdata",   32'(o_tag_wdata),    32'h0);
        chk("rst_done",    32'(o_flush_done),   32'h0);
        chk("rst_cen",     32'(o_cache_enable), 32'h0);
        chk("rst_count",   32'(o_flush_count),  32'h0);

        // ---- 1: power-on sweep, 256 cycles ----
        @(negedge i_clk);
        i_rst = 1'b0;
        walk(0, 256, errs);
        chk("t1_walk",  32'(errs),           32'h0);
        chk("t1_busy",  32'(o_flush_busy),   32'h0);
        chk("t1_done",  32'(o_flush_done),   32'h1);
        chk("t1_count", 32'(o_flush_count),  32'h1);
        chk("t1_cen",   32'(o_cache_enable), 32'h1);
        step();
        chk("t1_done_1cyc", 32'(o_flush_done), 32'h0);
        chk("t1_pulses",    32'(done_seen),    32'h1);

        // ---- 2: single strobe from IDLE ----
        strobe();
        chk("t2_busy",  32'(o_flush_busy),   32'h1);
        chk("t2_waddr", 32'(o_tag_waddr),    32'h0);
        chk("t2_cen",   32'(o_cache_enable), 32'h0);
        i_cache_enable = 1'b0;                    // toggling enable mid-sweep
        step();
        i_cache_enable = 1'b1;
        walk(1, 255, errs);
        chk("t2_walk",  32'(errs),           32'h0);
        chk("t2_done",  32'(o_flush_done),   32'h1);
        chk("t2_count", 32'(o_flush_count),  32'h2);
        chk("t2_cen",   32'(o_cache_enable), 32'h1);

        // ---- 3: ready alternating, each index presented two cycles ----
        strobe();
        exp_idx = 0;
        cyc     = 0;
        errs    = 0;
        while (o_flush_busy === 1'b1 && cyc < 600) begin
            i_tag_wready = cyc[0];
            if (o_tag_waddr !== 8'(exp_idx)) errs++;
            step();
            if (cyc[0]) exp_idx++;
            cyc++;
        end
        i_tag_wready = 1'b1;
        chk("t3_index", 32'(errs),          32'h0);
        chk("t3_cycles", 32'(cyc),          32'd512);
        chk("t3_lines", 32'(exp_idx),       32'd256);
        chk("t3_done",  32'(o_flush_done),  32'h1);
        chk("t3_count", 32'(o_flush_count), 32'h3);

        // ---- 4: restart at 100 and on the final write ----
        d0 = done_seen;
        strobe();
        walk(0, 100, errs);
        chk("t4_walk_a", 32'(errs),        32'h0);
        chk("t4_at100",  32'(o_tag_waddr), 32'd100);
        strobe();
        chk("t4_restart1", 32'(o_tag_waddr),  32'h0);
        chk("t4_busy1",    32'(o_flush_busy), 32'h1);
        walk(0, 255, errs);
        chk("t4_walk_b", 32'(errs),        32'h0);
        chk("t4_at255",  32'(o_tag_waddr), 32'd255);
        strobe();
        chk("t4_restart2", 32'(o_tag_waddr),   32'h0);
        chk("t4_busy2",    32'(o_flush_busy),  32'h1);
        chk("t4_count_hold", 32'(o_flush_count), 32'h3);
        walk(0, 256, errs);
        chk("t4_walk_c",  32'(errs),              32'h0);
        chk("t4_pulses",  32'(done_seen - d0),    32'h1);
        chk("t4_count",   32'(o_flush_count),     32'h4);

        // ---- 5: reset mid-sweep ----
        strobe();
        walk(0, 50, errs);
        chk("t5_at50", 32'(o_tag_waddr), 32'd50);
        #2 i_rst = 1'b1;
        #1;
        chk("t5_busy",  32'(o_flush_busy),   32'h1);
        chk("t5_waddr", 32'(o_tag_waddr),    32'h0);
        chk("t5_done",  32'(o_flush_done),   32'h0);
        chk("t5_cen",   32'(o_cache_enable), 32'h0);
        chk("t5_count", 32'(o_flush_count),  32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        walk(0, 256, errs);
        chk("t5_walk",  32'(errs),          32'h0);
        chk("t5_done2", 32'(o_flush_done),  32'h1);
        chk("t5_count2", 32'(o_flush_count), 32'h1);

        // ---- 6: saturation from 16'hfffe ----
        step();
        force dut.flush_count_q = 16'hfffe;
        #1 release dut.flush_count_q;
        chk("t6_preload", 32'(o_flush_count), 32'hfffe);
        d0 = done_seen;
        for (int s = 0; s < 3; s++) begin
            strobe();
            walk(0, 256, errs);
            chk($sformatf("t6_walk%0d", s),  32'(errs),          32'h0);
            chk($sformatf("t6_count%0d", s), 32'(o_flush_count), 32'hffff);
        end
        chk("t6_pulses", 32'(done_seen - d0), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
